// File: rtl/emu_ram_ckpt_ctrl_if.sv
// Checkpoint controller bundle: start requests, RAM scan-chain pins and the
// dump/restore word streams between the controller and its environment.
interface emu_ram_ckpt_ctrl_if #(
  parameter int WORD_WIDTH = 64
);
  logic                  start_dump;
  logic                  start_restore;
  logic                  halt;
  logic                  ram_scan;
  logic                  ram_dir;
  logic [WORD_WIDTH-1:0] ram_sdi;
  logic [WORD_WIDTH-1:0] ram_sdo;
  logic                  out_valid;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  in_valid;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  busy;
  logic                  done;
  logic                  underrun;

  // Handshakes: a dump word moves on every out_valid cycle (no backpressure);
  // a restore word moves when in_valid && in_ready. in_ready is high on every
  // restore shift cycle and never waits for in_valid: a missing word is
  // shifted as zero and flagged on underrun.
  modport master (
    input  start_dump, start_restore, ram_sdo, in_valid, in_data,
    output halt, ram_scan, ram_dir, ram_sdi, out_valid, out_data,
    output in_ready, busy, done, underrun
  );

  modport slave (
    output start_dump, start_restore, ram_sdo, in_valid, in_data,
    input  halt, ram_scan, ram_dir, ram_sdi, out_valid, out_data,
    input  in_ready, busy, done, underrun
  );
endinterface

// File: rtl/emu_ram_ckpt_ctrl.sv
// Emulator RAM checkpoint controller: halts the design, scans the RAM chain
// out (dump) or in (restore) one word per cycle, then resumes.
module emu_ram_ckpt_ctrl #(
  parameter int WORD_WIDTH   = 64,
  parameter int CHAIN_WORDS  = 16,
  parameter int SCAN_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  emu_ram_ckpt_ctrl_if.master   bus,
  output logic [2:0]            o_dbg_state
);

  localparam int CW = $clog2(CHAIN_WORDS + 1);
  localparam int LW = (SCAN_LATENCY > 1) ? $clog2(SCAN_LATENCY) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(CHAIN_WORDS - 1);
  localparam logic [LW-1:0] LAST_LAT  = LW'((SCAN_LATENCY > 0) ? (SCAN_LATENCY - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HALT   = 3'd1,
    S_PRE    = 3'd2,
    S_SHIFT  = 3'd3,
    S_POST   = 3'd4,
    S_UNSCAN = 3'd5,
    S_RESUME = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_dir;
  logic          r_underrun;
  logic [CW-1:0] r_word;
  logic [LW-1:0] r_lat;
  logic          w_accept;
  logic          w_shift;

  assign w_accept = (r_state == S_IDLE) && (bus.start_dump || bus.start_restore);
  assign w_shift  = (r_state == S_SHIFT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_HALT;
      S_HALT: begin
        // Restore needs no read latency; a zero-latency dump also skips PRE.
        if (r_dir || (SCAN_LATENCY == 0)) w_next = S_SHIFT;
        else                              w_next = S_PRE;
      end
      S_PRE:    if (r_lat == LAST_LAT) w_next = S_SHIFT;
      S_SHIFT:  if (r_word == LAST_WORD) w_next = r_dir ? S_POST : S_UNSCAN;
      S_POST:   w_next = S_UNSCAN;
      S_UNSCAN: w_next = S_RESUME;
      S_RESUME: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dir      <= 1'b0;
      r_underrun <= 1'b0;
      r_word     <= '0;
      r_lat      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        // Dump wins a simultaneous request.
        r_dir      <= ~bus.start_dump;
        r_underrun <= 1'b0;
      end else if (w_shift && r_dir && !bus.in_valid) begin
        r_underrun <= 1'b1;
      end
      r_word <= (w_shift && (r_word != LAST_WORD)) ? r_word + 1'b1 : '0;
      r_lat  <= ((r_state == S_PRE) && (r_lat != LAST_LAT)) ? r_lat + 1'b1 : '0;
    end
  end

  always_comb begin
    bus.halt      = (r_state != S_IDLE);
    bus.busy      = (r_state != S_IDLE);
    bus.ram_scan  = (r_state == S_PRE) || w_shift || (r_state == S_POST);
    bus.ram_dir   = r_dir && (r_state != S_IDLE);
    bus.out_valid = w_shift && !r_dir;
    bus.out_data  = '0;
    if (w_shift && !r_dir) bus.out_data = bus.ram_sdo;
    bus.in_ready  = w_shift && r_dir;
    bus.ram_sdi   = '0;
    if (w_shift && r_dir && bus.in_valid) bus.ram_sdi = bus.in_data;
    bus.done      = (r_state == S_RESUME);
    bus.underrun  = r_underrun;
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_emu_ram_ckpt_ctrl.sv
// Directed bench for emu_ram_ckpt_ctrl with a cycle-exact expected timeline
// and a small behavioural RAM chain for dump/restore loopback.
module tb_emu_ram_ckpt_ctrl;
  localparam int W  = 64;
  localparam int NW = 4;
  localparam int SL = 2;

  localparam int P_HALT   = 0;
  localparam int P_PRE    = 1;
  localparam int P_SHIFT  = 2;
  localparam int P_POST   = 3;
  localparam int P_UNSCAN = 4;
  localparam int P_RESUME = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  emu_ram_ckpt_ctrl_if #(.WORD_WIDTH(W)) bus ();

  emu_ram_ckpt_ctrl #(
    .WORD_WIDTH  (W),
    .CHAIN_WORDS (NW),
    .SCAN_LATENCY(SL)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] chain     [NW];
  logic [W-1:0] src_words [NW];
  logic [W-1:0] cap_words [NW];
  logic [W-1:0] orig      [NW];
  logic         exp_und;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Idle cycles carry junk on data inputs so leaks onto outputs are visible.
  task automatic drive_idle();
    bus.start_dump    = 1'b0;
    bus.start_restore = 1'b0;
    bus.ram_sdo       = 64'hBAD0_BAD1_BAD2_BAD3;
    bus.in_valid      = 1'b1;
    bus.in_data       = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_halt"},  W'(bus.halt),      W'(0));
    check({tag, "_busy"},  W'(bus.busy),      W'(0));
    check({tag, "_scan"},  W'(bus.ram_scan),  W'(0));
    check({tag, "_dir"},   W'(bus.ram_dir),   W'(0));
    check({tag, "_sdi"},   bus.ram_sdi,       '0);
    check({tag, "_oval"},  W'(bus.out_valid), W'(0));
    check({tag, "_odata"}, bus.out_data,      '0);
    check({tag, "_irdy"},  W'(bus.in_ready),  W'(0));
    check({tag, "_done"},  W'(bus.done),      W'(0));
    check({tag, "_und"},   W'(bus.underrun),  W'(exp_und));
  endtask

  task automatic run_op(input string name, input bit is_dump, input bit both,
                        input logic [NW-1:0] miss, input int inj_c);
    int    total;
    int    ph;
    int    k;
    string t;
    total = is_dump ? (1 + SL + NW + 1 + 1) : (1 + NW + 1 + 1 + 1);
    step();
    drive_idle();
    bus.start_dump    = is_dump | both;
    bus.start_restore = !is_dump | both;
    sample();
    check({name, "_c0_busy"}, W'(bus.busy),     W'(0));
    check({name, "_c0_und"},  W'(bus.underrun), W'(exp_und));
    exp_und = 1'b0;
    for (int c = 1; c <= total; c++) begin
      step();
      drive_idle();
      if (c == inj_c) begin
        bus.start_dump    = 1'b1;
        bus.start_restore = 1'b1;
      end
      k = 0;
      if (c == 1) ph = P_HALT;
      else if (is_dump) begin
        if (c <= 1 + SL) ph = P_PRE;
        else if (c <= 1 + SL + NW) begin ph = P_SHIFT; k = c - 2 - SL; end
        else if (c == total - 1) ph = P_UNSCAN;
        else ph = P_RESUME;
      end else begin
        if (c <= 1 + NW) begin ph = P_SHIFT; k = c - 2; end
        else if (c == 2 + NW) ph = P_POST;
        else if (c == total - 1) ph = P_UNSCAN;
        else ph = P_RESUME;
      end
      if (ph == P_SHIFT) begin
        if (is_dump) bus.ram_sdo = chain[k];
        else begin
          bus.in_valid = !miss[k];
          bus.in_data  = src_words[k];
        end
      end
      sample();
      t = $sformatf("%s_c%0d", name, c);
      check({t, "_halt"}, W'(bus.halt),     W'(1));
      check({t, "_busy"}, W'(bus.busy),     W'(1));
      check({t, "_scan"}, W'(bus.ram_scan), W'(ph == P_PRE || ph == P_SHIFT || ph == P_POST));
      check({t, "_dir"},  W'(bus.ram_dir),  W'(!is_dump));
      check({t, "_oval"}, W'(bus.out_valid), W'(ph == P_SHIFT && is_dump));
      check({t, "_odata"}, bus.out_data, (ph == P_SHIFT && is_dump) ? chain[k] : '0);
      check({t, "_irdy"}, W'(bus.in_ready), W'(ph == P_SHIFT && !is_dump));
      check({t, "_sdi"},  bus.ram_sdi,
            (ph == P_SHIFT && !is_dump && !miss[k]) ? src_words[k] : '0);
      check({t, "_done"}, W'(bus.done),     W'(c == total));
      check({t, "_und"},  W'(bus.underrun), W'(exp_und));
      if (ph == P_SHIFT) begin
        if (is_dump) cap_words[k] = bus.out_data;
        else begin
          chain[k] = bus.ram_sdi;
          if (miss[k]) exp_und = 1'b1;
        end
      end
    end
    step();
    drive_idle();
    sample();
    check_idle({name, "_end"});
  endtask

  initial begin
    rst     = 1'b1;
    exp_und = 1'b0;
    drive_idle();
    repeat (3) step();
    sample();
    check_idle("rst");
    step();
    rst = 1'b0;
    sample();
    check_idle("post_rst");

    // Dump of a known chain
    for (int k = 0; k < NW; k++) chain[k] = W'(16 + k);
    run_op("dump", 1'b1, 1'b0, 4'b0000, 0);
    for (int k = 0; k < NW; k++) check($sformatf("dump_w%0d", k), cap_words[k], W'(16 + k));

    // Clean restore
    for (int k = 0; k < NW; k++) begin
      src_words[k] = W'(8'hA0 + k);
      chain[k]     = '0;
    end
    run_op("rest", 1'b0, 1'b0, 4'b0000, 0);
    for (int k = 0; k < NW; k++) check($sformatf("rest_w%0d", k), chain[k], W'(8'hA0 + k));

    // Restore missing the third word; a start during POST must be ignored
    run_op("under", 1'b0, 1'b0, 4'b0100, 6);
    check("under_w2", chain[2], '0);
    check("under_w3", chain[3], W'(8'hA3));

    // Simultaneous starts -> dump; starts during PRE ignored
    for (int k = 0; k < NW; k++) chain[k] = W'(64'h5500 + k);
    run_op("both", 1'b1, 1'b1, 4'b0000, 3);

    // Reset in the middle of a restore shift with underrun set
    step();
    drive_idle();
    bus.start_restore = 1'b1;
    sample();
    for (int c = 1; c <= 3; c++) begin
      step();
      drive_idle();
      bus.in_valid = 1'b0;
      sample();
      check($sformatf("abort_c%0d_halt", c), W'(bus.halt), W'(1));
    end
    check("abort_und_set", W'(bus.underrun), W'(1));
    step();
    drive_idle();
    rst = 1'b1;
    sample();
    check("abort_pre_scan", W'(bus.ram_scan), W'(1));
    step();
    rst = 1'b0;
    sample();
    exp_und = 1'b0;
    check_idle("abort");
    for (int c = 0; c < 8; c++) begin
      step();
      sample();
      check($sformatf("abort_q%0d_done", c), W'(bus.done), W'(0));
      check($sformatf("abort_q%0d_busy", c), W'(bus.busy), W'(0));
    end

    // Loopback: dump a random chain, scramble it, restore the dumped words
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NW; k++) begin
        chain[k] = {$urandom, $urandom};
        orig[k]  = chain[k];
      end
      run_op($sformatf("lbd%0d", r), 1'b1, 1'b0, 4'b0000, 0);
      for (int k = 0; k < NW; k++) begin
        src_words[k] = cap_words[k];
        chain[k]     = ~orig[k];
      end
      run_op($sformatf("lbr%0d", r), 1'b0, 1'b0, 4'b0000, 0);
      for (int k = 0; k < NW; k++) check($sformatf("lb%0d_w%0d", r, k), chain[k], orig[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
